// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder built on one FullAdder_P cell, reused LSB first.
// Ports: clk, rst_n (async, active low); start, A, B, Cin capture an operation in IDLE;
//        busy (RUN/DONE), done (one-cycle result strobe); S, Cout, P_all, V registered results.
module FullAdder_P (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic p,
    output logic co
);
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             P_all,
    output logic             V
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, p_q, p_d, co_q, co_d, pall_q, pall_d, v_q, v_d;
    logic             fa_s, fa_p, fa_co;

    FullAdder_P u_fa (.a(a_q[0]), .b(b_q[0]), .ci(c_q), .s(fa_s), .p(fa_p), .co(fa_co));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        s_d     = s_q;
        co_d    = co_q;
        pall_d  = pall_q;
        v_d     = v_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = A;
                b_d     = B;
                c_d     = Cin;
                p_d     = 1'b1;
                cnt_d   = '0;
            end
            RUN: begin
                // Operands shift right so the cell always sees bit cnt at position 0;
                // result bits enter at the MSB and reach their place after WIDTH shifts.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_co;
                p_d   = p_q & fa_p;
                cnt_d = cnt_q + 1'b1;
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    s_d     = sum_d;
                    co_d    = fa_co;
                    pall_d  = p_d;
                    // c_q is still the carry entering the MSB at this edge
                    v_d     = c_q ^ fa_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            pall_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            co_q    <= co_d;
            pall_q  <= pall_d;
            v_q     <= v_d;
        end
    end

    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign S     = s_q;
    assign Cout  = co_q;
    assign P_all = pall_q;
    assign V     = v_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed vector bench for serial_add_seq at WIDTH=8.
module tb_serial_add_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       Cin = 1'b0;
    logic       busy, done, Cout, P_all, V;
    logic [7:0] S;
    int         n_chk = 0, n_fail = 0;

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] s;
        logic       co, pa, v;
    } vec_t;
    vec_t vecs[9];

    serial_add_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .S(S), .Cout(Cout), .P_all(P_all), .V(V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept at the next edge, scramble inputs after capture, then time the done pulse.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_op(input vec_t t, input string name);
        int cyc;
        @(negedge clk);
        A = t.a; B = t.b; Cin = t.cin; start = 1'b1;
        @(posedge clk);
        #1;
        chk({name, " busy"}, busy, 1'b1);
        @(negedge clk);
        start = 1'b0; A = ~t.a; B = t.a ^ 8'h5A; Cin = ~t.cin;
        wait_done(cyc);
        chk({name, " latency"}, cyc, 8);
        chk({name, " S"}, S, t.s);
        chk({name, " Cout"}, Cout, t.co);
        chk({name, " P_all"}, P_all, t.pa);
        chk({name, " V"}, V, t.v);
        @(posedge clk);
        #1;
        chk({name, " done drop"}, done, 1'b0);
        chk({name, " idle"}, busy, 1'b0);
    endtask

    initial begin
        int cyc, ndone, last_d;
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};

        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset S", S, 8'h00);
        chk("reset flags", {Cout, P_all, V}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // start pulse with new operands during RUN must be ignored
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'hFF; B = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        chk("ignore S held", S, 8'h80);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                chk("ignore S", S, 8'h46);
                chk("ignore Cout", Cout, 1'b0);
            end
        end
        chk("ignore single done", ndone, 1);

        // throughput with start held high
        @(negedge clk);
        A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
        ndone = 0; last_d = 0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (i == 30) start = 1'b0;
            if (done) begin
                chk("thru S", S, 8'h02);
                chk("thru spacing", i - last_d, ndone == 0 ? 9 : 10);
                last_d = i;
                ndone++;
            end
        end
        chk("thru count", ndone, 3);
        repeat (12) @(posedge clk);

        // reset mid-RUN aborts the operation
        @(negedge clk);
        A = 8'h40; B = 8'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort S", S, 8'h00);
        chk("abort flags", {Cout, P_all, V}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort no done", ndone, 0);

        // first start after reset release is honoured
        @(negedge clk);
        rst_n = 1'b0; A = 8'h03; B = 8'h04; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset accept", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("post-reset latency", cyc, 8);
        chk("post-reset S", S, 8'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset; one clock domain.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  operand A; captured on accepted start.
REQ-006 Port: B  input  WIDTH  operand B; captured on accepted start.
REQ-007 Port: Cin  input  1  carry-in; captured on accepted start.
REQ-008 Port: busy  output  1  high while in RUN or DONE.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: S  output  WIDTH  registered sum.
REQ-011 Port: Cout  output  1  registered carry-out of MSB.
REQ-012 Port: P_all  output  1  registered group propagate, AND of all per-bit P.
REQ-013 Port: V  output  1  registered signed overflow, carry into MSB XOR Cout.

Function
REQ-014 The block SHALL compute the sum using exactly one instance of the team's FullAdder_P single-bit cell (A, B, Cin -> S, P = A XOR B, Cout), time-shared LSB first.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 at an edge -> capture A, B, Cin into shift/carry registers, clear bit counter, set propagate accumulator to 1, go to RUN; start=0 -> stay.
REQ-017 RUN: each edge SHALL shift one result bit in (bit index = counter), update carry register with cell Cout, AND cell P into accumulator, increment counter.
REQ-018 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1; at that edge S, Cout, P_all, V output registers are loaded.
REQ-019 V SHALL be the XOR of the carry entering bit WIDTH-1 and the final Cout.
REQ-020 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-021 Latency: start sampled at edge 0 -> outputs updated at edge WIDTH -> done high during cycle between edges WIDTH and WIDTH+1.
REQ-022 Throughput: start held high continuously SHALL yield one accepted operation every WIDTH+2 cycles.
REQ-023 start during RUN or DONE SHALL be ignored, with no capture and no effect on the operation in flight.
REQ-024 Changes on A, B, Cin after capture SHALL NOT affect the result.
REQ-025 S, Cout, P_all, V SHALL hold their last loaded value until the next REQ-018 load, including through IDLE and a new RUN.
REQ-026 Carry out of MSB SHALL NOT wrap into bit 0; S is result mod 2^WIDTH.
REQ-027 busy SHALL be 0 in IDLE and 1 in RUN and DONE; done SHALL be 1 only in DONE.

Reset
REQ-028 rst_n low SHALL immediately, without a clock, force state IDLE and drive busy, done, S, Cout, P_all, V, counter, carry and shift registers to 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and no output load.
REQ-030 The first start after rst_n deassertion SHALL be honoured at the first rising edge at which rst_n is high.

Verification (WIDTH=8)
REQ-031 A=0xFF, B=0x01, Cin=0, start pulse -> done 8 cycles later; S=0x00, Cout=1, P_all=0, V=0.
REQ-032 A=0x0F, B=0xF0, Cin=1 -> S=0x00, Cout=1, P_all=1, V=0.
REQ-033 A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0, P_all=0, V=1.
REQ-034 Accept A=0x12, B=0x34; pulse start with A=0xFF, B=0xFF during RUN cycle 3 -> single done, S=0x46, Cout=0; next done only after a new start in IDLE.
REQ-035 Assert rst_n=0 during RUN cycle 4 -> busy, done, S, Cout, P_all, V read 0 asynchronously; no done pulse follows.
REQ-036 start held high for 30 cycles with A=0x01, B=0x01 -> done pulses every 10 cycles, S=0x02 each time.
